apb_slave_mem: RTL and testbench



---
 rtl/apb_slave_mem.sv | 165 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
//------------------------------------------------------------------------------
// Module      : apb_slave_mem
// Description : APB3 completer backed by a word-addressed register memory.
//               Every ACCESS phase inserts WAIT_STATES PREADY-low cycles.
//               Misaligned or out-of-range addresses complete with PSLVERR.
// Revision    : 1.0 - initial release
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESET   in   asynchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address [ADDR_WIDTH]
//   PWDATA   in   write data [DATA_WIDTH]
//   PSTRB    in   byte strobes [DATA_WIDTH/8] (only with APB_SLV_PSTRB_EN)
//   PRDATA   out  read data, zero unless a good read is completing
//   PREADY   out  transfer completes this cycle
//   PSLVERR  out  transfer error, only while PREADY is high
//
// Build option:
//   APB_SLV_PSTRB_EN  adds PSTRB and per-byte write enables
//------------------------------------------------------------------------------
`default_nettype none

module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int          c_NBYTES    = DATA_WIDTH / 8;
  localparam int          c_IDX_W     = ADDR_WIDTH - 2;
  localparam int          c_MIDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_DEPTH     = 32'(DEPTH);
  localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_STATES);

  localparam logic [0:0]  c_IDLE   = 1'b0;
  localparam logic [0:0]  c_ACCESS = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_state_nxt;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_NBYTES-1:0]     r_strb;
  logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

  logic                    w_setup;
  logic                    w_ready;
  logic                    w_commit;
  logic                    w_err;
  logic [c_IDX_W-1:0]      w_word_idx;
  logic [c_MIDX_W-1:0]     w_mem_idx;

  // Decode works only on the captured address, so mid-access changes to
  // PADDR cannot disturb the response.
  assign w_word_idx = r_addr[ADDR_WIDTH-1:2];
  assign w_mem_idx  = r_addr[c_MIDX_W+1:2];
  assign w_err      = (32'(w_word_idx) >= c_DEPTH) || (r_addr[1:0] != 2'b00);

  assign w_setup  = (r_state == c_IDLE) && PSEL && !PENABLE;
  assign w_ready  = (r_state == c_ACCESS) && (r_cnt == 4'd0);
  assign w_commit = w_ready && PSEL && PENABLE && r_write && !w_err;

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; dropping PSEL in ACCESS abandons the transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_state_nxt = c_ACCESS;
        end
      end
      c_ACCESS: begin
        if (!PSEL) begin
          w_state_nxt = c_IDLE;
        end else if (PENABLE && w_ready) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: driven from registered state, counter and memory only.
  always_comb begin
    PREADY  = w_ready;
    PSLVERR = w_ready && w_err;
    PRDATA  = '0;
    if (w_ready && !r_write && !w_err) begin
      PRDATA = r_mem[w_mem_idx];
    end
  end

  // Setup capture and wait-state counter
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_setup) begin
      r_cnt   <= c_WAIT_INIT;
      r_addr  <= PADDR;
      r_write <= PWRITE;
      r_wdata <= PWDATA;
`ifdef APB_SLV_PSTRB_EN
      r_strb  <= PSTRB;
`else
      r_strb  <= '1;
`endif
    end else if (r_state == c_ACCESS) begin
      if (!PSEL) begin
        r_cnt <= 4'd0;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Memory array; written only on a completion edge of a legal write.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      for (int b = 0; b < c_NBYTES; b++) begin
        if (r_strb[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
//------------------------------------------------------------------------------
// Module      : tb_apb_slave_mem
// Description : Directed self-checking bench for apb_slave_mem. A transfer-
//               level model (expected PREADY/PSLVERR/PRDATA per cycle plus a
//               word array) is compared against the DUT on every negedge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_slave_mem;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int WS    = 2;
`ifdef APB_SLV_PSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic          PCLK    = 1'b0;
  logic          PRESET  = 1'b0;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE  = 1'b0;
  logic [AW-1:0] PADDR   = '0;
  logic [DW-1:0] PWDATA  = '0;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]    PSTRB   = 4'h0;
`endif
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB  (PSTRB),
`endif
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model_mem [0:DEPTH-1];
  bit          check_en      = 1'b0;
  logic        exp_ready     = 1'b0;
  logic        exp_err       = 1'b0;
  logic [31:0] exp_rdata     = '0;
  bit          exp_rdata_chk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the transfer model
  always @(negedge PCLK) begin
    if (check_en && !PRESET) begin
      check("PREADY", 32'(PREADY), 32'(exp_ready));
      check("PSLVERR", 32'(PSLVERR), 32'(exp_err));
      if (exp_rdata_chk) check("PRDATA", PRDATA, exp_rdata);
    end
  end

  task automatic clear_exp();
    exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_rdata_chk = 1'b1;
  endtask

  task automatic idle(input int n);
    PSEL = 1'b0; PENABLE = 1'b0;
    clear_exp();
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // One APB transfer. abort_at >= 0 drops PSEL in that wait-state cycle.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input int abort_at,
                      output logic [31:0] rd, output logic er);
    int         idx;
    bit         bad;
    logic [3:0] eff;
    idx = int'(addr >> 2);
    bad = (idx >= DEPTH) || (addr[1:0] != 2'b00);
    eff = STRB_EN ? strb : 4'hF;
    rd  = '0;
    er  = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
`ifdef APB_SLV_PSTRB_EN
    PSTRB = strb;
`endif
    clear_exp();
    @(posedge PCLK); #1;
    // Scramble the inputs that must have been captured at setup
    PENABLE = 1'b1; PADDR = ~addr; PWDATA = ~wd; PWRITE = ~wr;
`ifdef APB_SLV_PSTRB_EN
    PSTRB = ~strb;
`endif
    for (int i = 0; i < WS; i++) begin
      if (i == abort_at) begin
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        return;
      end
      @(posedge PCLK); #1;
    end
    exp_ready     = 1'b1;
    exp_err       = bad;
    exp_rdata     = (!wr && !bad) ? model_mem[idx] : 32'h0;
    exp_rdata_chk = !wr;
    @(negedge PCLK);
    rd = PRDATA;
    er = PSLVERR;
    @(posedge PCLK); #1;
    if (wr && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (eff[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    clear_exp();
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] b2b_data [0:3];

  initial begin
    b2b_data[0] = 32'h0BAD_F00D;
    b2b_data[1] = 32'h1357_9BDF;
    b2b_data[2] = 32'h2468_ACE0;
    b2b_data[3] = 32'hFEDC_BA98;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Asynchronous reset, asserted mid-cycle
    #2 PRESET = 1'b1;
    #1;
    check("rst_PREADY", 32'(PREADY), 32'h0);
    check("rst_PSLVERR", 32'(PSLVERR), 32'h0);
    check("rst_PRDATA", PRDATA, 32'h0);
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    check_en = 1'b1;
    idle(1);

    xfer(1'b0, 8'h00, 32'h0, 4'hF, -1, rd, er);
    check("read0_after_reset", rd, 32'h0000_0000);

    // Write then immediate read
    xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, -1, rd, er);
    check("wr10_err", 32'(er), 32'h0);
    xfer(1'b0, 8'h10, 32'h0, 4'hF, -1, rd, er);
    check("rd10_data", rd, 32'hDEAD_BEEF);
    check("rd10_err", 32'(er), 32'h0);
    idle(2);

    // Illegal addresses and the last legal word
    xfer(1'b1, 8'hFC, 32'h1234_5678, 4'hF, -1, rd, er);
    check("wrFC_err", 32'(er), 32'h1);
    xfer(1'b0, 8'h02, 32'h0, 4'hF, -1, rd, er);
    check("rd02_err", 32'(er), 32'h1);
    check("rd02_data", rd, 32'h0);
    xfer(1'b0, 8'h80, 32'h0, 4'hF, -1, rd, er);
    check("rd80_err", 32'(er), 32'h1);
    xfer(1'b1, 8'h7E, 32'h1111_1111, 4'hF, -1, rd, er);
    check("wr7E_err", 32'(er), 32'h1);
    xfer(1'b1, 8'h7C, 32'h7C7C_0001, 4'hF, -1, rd, er);
    xfer(1'b0, 8'h7C, 32'h0, 4'hF, -1, rd, er);
    check("rd7C_data", rd, 32'h7C7C_0001);
    check("rd7C_err", 32'(er), 32'h0);
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 8'(4 * i), 32'h0, 4'hF, -1, rd, er);
    idle(1);

    // Aborted writes leave the word alone
    xfer(1'b1, 8'h04, 32'h0102_0304, 4'hF, -1, rd, er);
    idle(1);
    xfer(1'b1, 8'h04, 32'hAAAA_5555, 4'hF, 1, rd, er);
    idle(2);
    xfer(1'b1, 8'h04, 32'hBBBB_CCCC, 4'hF, 0, rd, er);
    idle(1);
    xfer(1'b0, 8'h04, 32'h0, 4'hF, -1, rd, er);
    check("abort_rd04", rd, 32'h0102_0304);
    idle(1);

    // PENABLE without a setup phase is ignored
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'hFFFF_FFFF;
    repeat (3) @(posedge PCLK);
    #1;
    xfer(1'b0, 8'h04, 32'h0, 4'hF, -1, rd, er);
    check("noset_rd04", rd, 32'h0102_0304);

    // Back-to-back writes then reads, no idle cycles
    for (int i = 0; i < 4; i++) xfer(1'b1, 8'(4 * i), b2b_data[i], 4'hF, -1, rd, er);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 8'(4 * i), 32'h0, 4'hF, -1, rd, er);
      check("b2b_rd", rd, b2b_data[i]);
    end
    idle(1);

    // Byte strobes (full-word write when the option is absent)
    xfer(1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, -1, rd, er);
    xfer(1'b1, 8'h20, 32'h1122_3344, 4'b0101, -1, rd, er);
    xfer(1'b0, 8'h20, 32'h0, 4'hF, -1, rd, er);
    check("strb_rd20", rd, STRB_EN ? 32'hFF22_FF44 : 32'h1122_3344);
    xfer(1'b1, 8'h20, 32'h0, 4'b0000, -1, rd, er);
    check("strb0_err", 32'(er), 32'h0);
    xfer(1'b0, 8'h20, 32'h0, 4'hF, -1, rd, er);
    check("strb0_rd20", rd, STRB_EN ? 32'hFF22_FF44 : 32'h0000_0000);
    idle(1);

    // Reset asserted during a read completion cycle
    check_en = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h10;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (WS) @(posedge PCLK);
    @(negedge PCLK);
    check("pre_rst_PREADY", 32'(PREADY), 32'h1);
    check("pre_rst_PRDATA", PRDATA, 32'hDEAD_BEEF);
    #2 PRESET = 1'b1;
    #1;
    check("mid_rst_PREADY", 32'(PREADY), 32'h0);
    check("mid_rst_PRDATA", PRDATA, 32'h0);
    check("mid_rst_PSLVERR", 32'(PSLVERR), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    clear_exp();
    check_en = 1'b1;
    xfer(1'b0, 8'h10, 32'h0, 4'hF, -1, rd, er);
    check("post_rst_rd10", rd, 32'h0);
    xfer(1'b0, 8'h00, 32'h0, 4'hF, -1, rd, er);
    check("post_rst_rd00", rd, 32'h0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
